// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment driver for the alarm-clock display.
// Scans NUM_DIGITS BCD digits onto one active-low segment bus with one-cold,
// active-low anodes. Each digit slot starts with a dead-time window to stop ghosting.
// New digit data is latched into a shadow copy only at frame boundaries, so a
// frame never shows a mix of old and new values.
// Optional feature: define DISP_BLINK_EN to enable per-digit blinking driven by
// blink_mask. Without it, blink_mask is accepted but has no effect.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    update,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    // Counter widths. The digit index keeps at least one bit so that a
    // single-digit build still has a legal index register.
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    // Scan position
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             boundary;

    // Shadow copy of the display data, changed only at frame boundaries
    logic [3:0]            digit_vec     [NUM_DIGITS];
    logic [3:0]            shadow_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] shadow_mask;
    logic                  pending;

    // Values for the digit currently being scanned
    logic       blink_phase;
    logic [3:0] cur_code;
    logic       cur_dp;
    logic       cur_hide;
    logic       in_blank;

    // BCD to active-low {a,b,c,d,e,f,g}. Codes 10..15 turn every segment off.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Split the packed BCD input into one 4-bit code per digit
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
        assign digit_vec[gi] = digits_in[4*gi +: 4];
    end

    // Last cycle of the last digit slot, and only while scanning
    assign boundary = en && (cnt == CNT_LAST) && (idx == IDX_LAST);

`ifdef DISP_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;

    // Free-running blink timebase. It ignores en so the blink rhythm stays
    // steady when the display is switched off and back on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end
`else
    // Blinking is compiled out, so digits are never hidden
    assign blink_phase = 1'b0;
`endif

    // Look up the current digit's shadow data and the dead-time window
    always_comb begin
        cur_code = shadow_digits[idx];
        cur_dp   = shadow_dp[idx];
        cur_hide = blink_phase & shadow_mask[idx];
        in_blank = (cnt < BLANK_END);
    end

    // Slot counter, digit index and frame pulse. Dropping en parks the scan at slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Latch update requests. Copy new data into the shadow only at a frame boundary.
    // A request that arrives on the boundary cycle itself is captured at once and
    // does not set pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digits <= '{default: 4'hF};
            shadow_dp     <= '0;
            shadow_mask   <= '0;
            pending       <= 1'b0;
        end else if (boundary && (pending || update)) begin
            shadow_digits <= digit_vec;
            shadow_dp     <= dp_in;
            shadow_mask   <= blink_mask;
            pending       <= 1'b0;
        end else if (update) begin
            pending       <= 1'b1;
        end
    end

    // Registered display outputs, one cycle behind the scan position.
    // During dead time or when disabled everything is off. A blinked digit keeps
    // its anode active but shows no segments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg  <= 7'b1111111;
            dp_n <= 1'b1;
            an   <= '1;
        end else if (!en || in_blank) begin
            seg  <= 7'b1111111;
            dp_n <= 1'b1;
            an   <= '1;
        end else begin
            an <= ~(NUM_DIGITS'(1) << idx);
            if (cur_hide) begin
                seg  <= 7'b1111111;
                dp_n <= 1'b1;
            end else begin
                seg  <= decode(cur_code);
                dp_n <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed testbench for seg7_scan_driver (4 digits, 8-cycle slots, 2 dead-time
// cycles, 64-cycle blink half-period). Expected segment patterns are written out
// by hand for every frame.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic        update;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    int passed = 0;
    int total  = 0;
    int ncyc   = 0;

`ifdef DISP_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    localparam logic [27:0] SEGS_BLANK = {4{7'b1111111}};
    // Segment patterns packed as {digit3, digit2, digit1, digit0}
    localparam logic [27:0] SEGS_1234 = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
    localparam logic [27:0] SEGS_5678 = {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000};
    localparam logic [27:0] SEGS_0A90 = {7'b0000001, 7'b1111111, 7'b0001100, 7'b0000001};
    localparam logic [27:0] SEGS_4321 = {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};

    always #5 clk = ~clk;

    // Count rising edges since reset release; this tracks the blink phase
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2),
        .BLINK_DIV   (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .blink_mask(blink_mask),
        .update    (update),
        .seg       (seg),
        .dp_n      (dp_n),
        .an        (an),
        .frame_done(frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {an, seg, dp_n, frame_done} after the j-th edge of a frame (j = 1..32).
    // The frame starts at the edge where frame_done is seen high.
    function automatic logic [12:0] frame_exp(input int j, input logic [27:0] segs,
                                              input logic [3:0] dps, input logic [3:0] hide);
        int d = (j - 1) / 8;
        int c = (j - 1) % 8;
        logic [12:0] r;
        r = {4'b1111, 7'b1111111, 1'b1, (j == 32)};
        if (c >= 2) begin
            r[12:9] = ~(4'b0001 << d);
            if (!hide[d]) begin
                r[8:2] = segs[7*d +: 7];
                r[1]   = ~dps[d];
            end
        end
        return r;
    endfunction

    // Bounded wait for the next frame_done pulse
    task automatic wait_frame();
        int n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (frame_done !== 1'b1) begin
            total++;
            $display("FAIL wait_frame: frame_done=%b after %0d cycles, required 1", frame_done, n);
        end
    endtask

    task automatic test_reset();
        logic [12:0] e;
        rst_n = 1'b0; en = 1'b0; update = 1'b0;
        digits_in = 16'h0000; dp_in = 4'h0; blink_mask = 4'h0;
        repeat (3) tick();
        rst_n = 1'b1; en = 1'b1;
        repeat (13) tick();
        // Assert reset between clock edges: outputs must go dark without waiting for clk
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({seg, dp_n, an, frame_done} !== {7'b1111111, 1'b1, 4'b1111, 1'b0})
            $display("FAIL reset_async: seg=%b dp_n=%b an=%b fd=%b required 1111111 1 1111 0",
                     seg, dp_n, an, frame_done);
        else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            tick();
            e = frame_exp(j, SEGS_BLANK, 4'h0, 4'h0);
            total++;
            if ({an, seg, dp_n, frame_done} !== e)
                $display("FAIL reset_scan j%0d: an/seg/dp/fd=%b required %b", j,
                         {an, seg, dp_n, frame_done}, e);
            else passed++;
        end
    endtask

    task automatic test_update();
        logic [12:0] e;
        digits_in = 16'h1234; dp_in = 4'h0;
        update = 1'b1;
        tick();
        update = 1'b0;
        wait_frame();
        for (int j = 1; j <= 32; j++) begin
            tick();
            e = frame_exp(j, SEGS_1234, 4'h0, 4'h0);
            total++;
            if ({an, seg, dp_n, frame_done} !== e)
                $display("FAIL update_1234 j%0d: an/seg/dp/fd=%b required %b", j,
                         {an, seg, dp_n, frame_done}, e);
            else passed++;
        end
    endtask

    task automatic test_midframe();
        logic [12:0] e;
        for (int f = 0; f < 2; f++) begin
            for (int j = 1; j <= 32; j++) begin
                tick();
                e = frame_exp(j, (f == 0) ? SEGS_1234 : SEGS_5678, 4'h0, 4'h0);
                total++;
                if ({an, seg, dp_n, frame_done} !== e)
                    $display("FAIL midframe f%0d j%0d: an/seg/dp/fd=%b required %b", f, j,
                             {an, seg, dp_n, frame_done}, e);
                else passed++;
                if (f == 0 && j == 10) begin
                    digits_in = 16'h5678;
                    update = 1'b1;
                end
                if (f == 0 && j == 11) update = 1'b0;
            end
        end
    endtask

    task automatic test_boundary_update();
        logic [12:0] e;
        logic [27:0] s;
        logic [3:0]  p;
        for (int f = 0; f < 3; f++) begin
            for (int j = 1; j <= 32; j++) begin
                tick();
                s = (f == 0) ? SEGS_5678 : SEGS_0A90;
                p = (f == 0) ? 4'b0000 : 4'b0100;
                e = frame_exp(j, s, p, 4'h0);
                total++;
                if ({an, seg, dp_n, frame_done} !== e)
                    $display("FAIL boundary_upd f%0d j%0d: an/seg/dp/fd=%b required %b", f, j,
                             {an, seg, dp_n, frame_done}, e);
                else passed++;
                // Strobe update exactly on the boundary cycle
                if (f == 0 && j == 31) begin
                    digits_in = 16'h0A90;
                    dp_in = 4'b0100;
                    update = 1'b1;
                end
                if (f == 0 && j == 32) update = 1'b0;
                // Change the input without update; it must never reach the display
                if (f == 1 && j == 5) begin
                    digits_in = 16'h1111;
                    dp_in = 4'b0000;
                end
            end
        end
    endtask

    task automatic test_enable();
        logic [12:0] e;
        for (int j = 1; j <= 21; j++) begin
            tick();
            e = frame_exp(j, SEGS_0A90, 4'b0100, 4'h0);
            total++;
            if ({an, seg, dp_n, frame_done} !== e)
                $display("FAIL enable_pre j%0d: an/seg/dp/fd=%b required %b", j,
                         {an, seg, dp_n, frame_done}, e);
            else passed++;
        end
        // Drop en in the middle of slot 2, and request an update while dark
        en = 1'b0;
        digits_in = 16'h4321; dp_in = 4'h0; update = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            update = 1'b0;
            total++;
            if ({an, seg, dp_n, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
                $display("FAIL enable_off k%0d: an/seg/dp/fd=%b required 1111_1111111_1_0", k,
                         {an, seg, dp_n, frame_done});
            else passed++;
        end
        en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int j = 1; j <= 32; j++) begin
                tick();
                e = (f == 0) ? frame_exp(j, SEGS_0A90, 4'b0100, 4'h0)
                             : frame_exp(j, SEGS_4321, 4'b0000, 4'h0);
                total++;
                if ({an, seg, dp_n, frame_done} !== e)
                    $display("FAIL enable_on f%0d j%0d: an/seg/dp/fd=%b required %b", f, j,
                             {an, seg, dp_n, frame_done}, e);
                else passed++;
            end
        end
    endtask

    task automatic test_blink();
        logic [12:0] e;
        logic [3:0]  h;
        blink_mask = 4'b0001; dp_in = 4'b0001; update = 1'b1;
        tick();
        update = 1'b0;
        wait_frame();
        for (int f = 0; f < 8; f++) begin
            for (int j = 1; j <= 32; j++) begin
                tick();
                // The output after edge k shows the blink phase held before edge k
                h = {3'b000, BLINK_ON && ((((ncyc - 1) / 64) % 2) == 1)};
                e = frame_exp(j, SEGS_4321, 4'b0001, h);
                total++;
                if ({an, seg, dp_n, frame_done} !== e)
                    $display("FAIL blink f%0d j%0d ncyc%0d: an/seg/dp/fd=%b required %b", f, j,
                             ncyc, {an, seg, dp_n, frame_done}, e);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_update();
        test_midframe();
        test_boundary_update();
        test_enable();
        test_blink();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Multiplexed multi-digit 7-segment display driver for the alarm-clock display path. It time-division scans NUM_DIGITS BCD digits onto one shared active-low segment bus with per-digit active-low anode enables. It adds anti-ghosting dead time, tear-free frame-synchronous updates and optional per-digit blinking. It replaces per-digit combinational decoders feeding the board display.

Parameters:
NUM_DIGITS, 4, digits scanned; legal 1..8
SCAN_DIV, 100000, clock cycles per digit slot; legal >= 2
BLANK_CYCLES, 1000, dead-time cycles at start of each slot; legal 0..SCAN_DIV-1
BLINK_DIV, 25000000, clock cycles per blink half-period (only used with DISP_BLINK_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; 0 = display dark
digits_in  input  4*NUM_DIGITS  BCD codes; digit i = bits [4i+3:4i], digit 0 rightmost
dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
blink_mask  input  NUM_DIGITS  1 = digit blinks (ignored without DISP_BLINK_EN)
update  input  1  one-cycle strobe requesting capture of digits_in/dp_in/blink_mask
seg  output  7  segments {a,b,c,d,e,f,g}, a = bit 6, active-low
dp_n  output  1  decimal point, active-low
an  output  NUM_DIGITS  anode enables, an[i] drives digit i, active-low
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n).
- Reset: seg=7'b1111111, dp_n=1, an=all 1s, frame_done=0, slot counter cnt=0, digit index idx=0, pending=0, shadow digits all 4'hF, shadow dp 0, shadow mask 0, blink phase 0.
- cnt counts 0..SCAN_DIV-1 while en=1; at cnt==SCAN_DIV-1, cnt->0 and idx advances, NUM_DIGITS-1 wraps to 0.
- Frame boundary = cycle with cnt==SCAN_DIV-1 and idx==NUM_DIGITS-1. frame_done registered, high the following cycle.
- update sets pending. At frame boundary, if pending or update high that cycle: shadow <= digits_in, dp_in, blink_mask; pending cleared. update arriving on the boundary cycle itself is captured that cycle, pending stays 0. No mid-frame shadow change.
- Outputs are registered: one cycle latency from (cnt, idx, shadow) to seg/dp_n/an.
- Blank window: cnt < BLANK_CYCLES -> an all 1s, seg all 1s, dp_n=1.
- Active window: an = one-cold at idx; seg = decode(shadow[idx]); dp_n = ~shadow_dp[idx].
- Decode table (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100; codes 10..15 = 1111111 (blank, dp still honoured). Full case, no latches.
- en=0: cnt->0, idx->0 next cycle; outputs all 1s the following cycle; shadow and pending retained, update still captured into pending; frame_done held 0. Re-enable restarts at slot 0 with blank window.
- NUM_DIGITS=1: every slot end is a frame boundary; an is 1 bit.

Optional Feature:
DISP_BLINK_EN: when defined, a blink counter counts 0..BLINK_DIV-1 and toggles blink phase at wrap, free-running while rst_n high (independent of en). During phase=1, digits with shadow mask bit set show seg=1111111 and dp_n=1 while an still scans normally. When undefined: no blink counter, blink_mask port present but ignored, phase constant 0.

Test Plan:
Params NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, BLINK_DIV=64.
Reset asserted mid-scan -> immediately seg=1111111, dp_n=1, an=1111, frame_done=0; after release with en=1, an scans 1110,1101,1011,0111 with seg=1111111 (blank shadow).
digits_in=16'h1234, update pulse -> after next frame_done, digit 0 slot: an=1110, seg=1001100, cycles 3..8 of slot (blank 0..1, +1 latency); digit 3 slot shows 0001111? no: digit 3 = '1' = 1001111.
digits_in changed to 16'h5678 mid-frame with update -> current frame still shows 1234; next frame shows 5678; frame_done pulses once per 32 cycles.
Code 4'hA on digit 2 with dp_in=0100 -> digit 2 slot seg=1111111, dp_n=0.
en dropped mid-slot 2 -> one cycle later all outputs 1s; en raised -> first lit anode is an=1110 after 2 blank cycles.
With DISP_BLINK_EN, blink_mask=0001 captured -> digit 0 lit for 64 cycles, blank for 64, repeating; other digits unaffected; without macro digit 0 always lit.
